// File: rtl/riscv_defines.sv
// Shared definitions for the DIFT security-exception controller.
package riscv_defines;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAP   = 2'd1,
    LOCKED = 2'd2
  } exc_state_e;

  localparam logic [1:0] CFG_CTRL   = 2'd0;
  localparam logic [1:0] CFG_STATUS = 2'd1;
  localparam logic [1:0] CFG_EPC    = 2'd2;
  localparam logic [1:0] CFG_COUNT  = 2'd3;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_LOCK   = 1;
  localparam int ST_LOCKED   = 0;
  localparam int ST_OVF      = 1;
  localparam int ST_CAUSE_LO = 8;

endpackage

// File: rtl/riscv_dift_exc_ctrl_if.sv
// Signal bundle around the DIFT exception controller:
// EX feed, trap handshake and config bus.
interface riscv_dift_exc_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             exception;
  logic             ex_valid;
  logic [31:0]      pc_ex;
  logic [2:0]       check_vec;
  logic             trap_req;
  logic             trap_ack;
  logic [31:0]      trap_pc;
  logic [2:0]       trap_cause;
  logic             halt;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;
  logic [CNT_W-1:0] exc_count;

  modport master (
    output exception, ex_valid, pc_ex, check_vec,
    output trap_ack, cfg_we, cfg_addr, cfg_wdata,
    input  trap_req, trap_pc, trap_cause, halt,
    input  cfg_rdata, exc_count
  );

  modport slave (
    input  exception, ex_valid, pc_ex, check_vec,
    input  trap_ack, cfg_we, cfg_addr, cfg_wdata,
    output trap_req, trap_pc, trap_cause, halt,
    output cfg_rdata, exc_count
  );
endinterface

// File: rtl/riscv_dift_exc_ctrl.sv
// DIFT tag-check exception controller: captures the first
// faulting PC/cause, raises a trap, optionally locks the core.
module riscv_dift_exc_ctrl #(
  parameter int EXC_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exception_i,
  input  logic                     ex_valid_i,
  input  logic [31:0]              pc_ex_i,
  input  logic [2:0]               check_vec_i,
  output logic                     trap_req_o,
  input  logic                     trap_ack_i,
  output logic [31:0]              trap_pc_o,
  output logic [2:0]               trap_cause_o,
  output logic                     halt_o,
  input  logic                     cfg_we_i,
  input  logic [1:0]               cfg_addr_i,
  input  logic [31:0]              cfg_wdata_i,
  output logic [31:0]              cfg_rdata_o,
  output logic [EXC_CNT_WIDTH-1:0] exc_count_o
);
  import riscv_defines::*;

  exc_state_e state_q, state_d;

  logic                     en_q, lock_q;
  logic                     locked_q, ovf_q;
  logic [2:0]               cause_q;
  logic [31:0]              epc_q;
  logic [EXC_CNT_WIDTH-1:0] cnt_q;

  logic capture, idle;
  logic wr_ctrl, wr_status, wr_count;
  logic unlock, clr_ovf;
  logic unused_wdata;

  assign capture   = exception_i & ex_valid_i & en_q;
  assign idle      = (state_q == IDLE);
  assign wr_ctrl   = cfg_we_i & (cfg_addr_i == CFG_CTRL);
  assign wr_status = cfg_we_i & (cfg_addr_i == CFG_STATUS);
  assign wr_count  = cfg_we_i & (cfg_addr_i == CFG_COUNT);
  assign unlock    = wr_status & cfg_wdata_i[ST_LOCKED];
  assign clr_ovf   = wr_status & cfg_wdata_i[ST_OVF];

  assign unused_wdata = ^cfg_wdata_i[31:2];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (capture) state_d = TRAP;
      TRAP:    if (trap_ack_i) state_d = lock_q ? LOCKED : IDLE;
      LOCKED:  if (unlock) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= 1'b0;
      lock_q   <= 1'b0;
      locked_q <= 1'b0;
      ovf_q    <= 1'b0;
      cause_q  <= '0;
      epc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ctrl) begin
        en_q   <= cfg_wdata_i[CTRL_EN];
        lock_q <= cfg_wdata_i[CTRL_LOCK];
      end
      // Only the first fault of a sequence is recorded
      if (capture && idle) begin
        epc_q   <= pc_ex_i;
        cause_q <= check_vec_i;
      end
      if (state_q == TRAP && trap_ack_i && lock_q)
        locked_q <= 1'b1;
      else if (unlock)
        locked_q <= 1'b0;
      // A new overflow beats a same-cycle clear
      if (capture && !idle)
        ovf_q <= 1'b1;
      else if (clr_ovf)
        ovf_q <= 1'b0;
      if (wr_count)
        cnt_q <= EXC_CNT_WIDTH'(capture);
      else if (capture && cnt_q != '1)
        cnt_q <= cnt_q + EXC_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    unique case (cfg_addr_i)
      CFG_CTRL: begin
        cfg_rdata_o[CTRL_EN]   = en_q;
        cfg_rdata_o[CTRL_LOCK] = lock_q;
      end
      CFG_STATUS: begin
        cfg_rdata_o[ST_LOCKED]        = locked_q;
        cfg_rdata_o[ST_OVF]           = ovf_q;
        cfg_rdata_o[ST_CAUSE_LO +: 3] = cause_q;
      end
      CFG_EPC:   cfg_rdata_o = epc_q;
      CFG_COUNT: cfg_rdata_o = 32'(cnt_q);
      default:   cfg_rdata_o = '0;
    endcase
  end

  assign trap_req_o   = (state_q == TRAP);
  assign halt_o       = !idle;
  assign trap_pc_o    = epc_q;
  assign trap_cause_o = cause_q;
  assign exc_count_o  = cnt_q;

endmodule

// File: doc/riscv_dift_exc_ctrl.md
RISCV_DIFT_EXC_CTRL -- requirements
Module: riscv_dift_exc_ctrl

Interface
REQ-001 SHALL have parameter EXC_CNT_WIDTH, default 8: width of the saturating exception counter.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port exception_i  in  1  tag-check exception flag from EX.
REQ-005 SHALL have port ex_valid_i  in  1  EX instruction completes this cycle.
REQ-006 SHALL have port pc_ex_i  in  32  PC of the instruction in EX.
REQ-007 SHALL have port check_vec_i  in  3  {check_d, check_s2, check_s1} enables of that instruction; this is the cause.
REQ-008 SHALL have port trap_req_o  out  1  security-trap request to the controller.
REQ-009 SHALL have port trap_ack_i  in  1  controller accepts the trap.
REQ-010 SHALL have port trap_pc_o  out  32  captured faulting PC.
REQ-011 SHALL have port trap_cause_o  out  3  captured check_vec_i.
REQ-012 SHALL have port halt_o  out  1  stall request to the pipeline.
REQ-013 SHALL have port cfg_we_i  in  1  configuration write strobe.
REQ-014 SHALL have port cfg_addr_i  in  2  register select.
REQ-015 SHALL have port cfg_wdata_i  in  32  write data.
REQ-016 SHALL have port cfg_rdata_o  out  32  read data, combinational from cfg_addr_i.
REQ-017 SHALL have port exc_count_o  out  EXC_CNT_WIDTH  exception counter value.

Function
REQ-018 SHALL implement the register map: 0 CTRL (bit0 enable, bit1 lock_en; RW); 1 STATUS (bit0 locked, bit1 overflow, bits[10:8] last cause; bits 0 and 1 are write-1-to-clear); 2 EPC (RO); 3 COUNT (RO, any write clears it); unused bits read 0.
REQ-019 SHALL define the capture event as exception_i & ex_valid_i & CTRL.enable.
REQ-020 SHALL implement FSM states IDLE, TRAP and LOCKED.
REQ-021 SHALL, in IDLE on a capture event, go to TRAP next cycle, latch EPC=pc_ex_i and cause=check_vec_i, and increment COUNT.
REQ-022 SHALL assert trap_req_o=1 iff state==TRAP (registered; first asserted the cycle after capture), and hold it until trap_ack_i.
REQ-023 SHALL sample trap_ack_i only in TRAP; on ack go to LOCKED (setting STATUS.locked) if CTRL.lock_en, else to IDLE.
REQ-024 SHALL leave LOCKED only on a cfg write to STATUS with wdata[0]=1, going to IDLE next cycle.
REQ-025 SHALL assert halt_o=1 iff state!=IDLE.
REQ-026 SHALL, on a capture event in TRAP or LOCKED, not overwrite EPC/cause, set STATUS.overflow and still increment COUNT.
REQ-027 SHALL make COUNT saturate at 2^EXC_CNT_WIDTH-1 with no wrap.
REQ-028 SHALL, when a COUNT clear and an increment occur in the same cycle, leave COUNT=1.
REQ-029 SHALL, when a W1C of overflow coincides with a new overflow event, leave overflow set (set wins).
REQ-030 SHALL, when CTRL.enable is cleared while in TRAP or LOCKED, complete the current sequence normally.
REQ-031 SHALL drive trap_pc_o and trap_cause_o from EPC and the latched cause continuously.

Reset
REQ-032 SHALL, on rst=1 (asynchronous), set state=IDLE, CTRL=0, STATUS=0, EPC=0, COUNT=0, with all outputs 0 for the duration of reset.
REQ-033 SHALL abandon an in-flight TRAP on reset: trap_req_o drops immediately and no ack is expected.

Structure
REQ-034 SHALL place the FSM state enum, the CFG address constants (CTRL/STATUS/EPC/COUNT) and the STATUS bit positions in riscv_defines.
REQ-035 SHALL be a single module with no sub-module, instantiated alongside EX and fed from the EX tag-check output.

Verification
REQ-036 SHALL cover: enable=1, exception at pc 0x0000_0100 with check_vec 3'b010 -> trap_req next cycle, trap_pc 0x100, trap_cause 2, COUNT=1; ack -> IDLE, halt_o low.
REQ-037 SHALL cover: lock_en=1, exception then ack -> LOCKED, halt_o=1, STATUS=0x001|cause<<8; write STATUS 0x1 -> IDLE next cycle.
REQ-038 SHALL cover: second exception at pc 0x200 while in TRAP -> EPC stays 0x100, overflow=1, COUNT=2.
REQ-039 SHALL cover: EXC_CNT_WIDTH=2 with 5 exceptions -> COUNT=3; COUNT clear coinciding with an exception -> COUNT=1.
REQ-040 SHALL cover: enable=0 with exception_i=1 -> no trap and COUNT=0; exception_i=1 with ex_valid_i=0 -> no capture.
REQ-041 SHALL cover: rst pulse mid-TRAP -> trap_req_o=0 and halt_o=0 asynchronously, all registers 0.
